// File: rtl/tpi_multiport.sv
// Multi-port parallel I/O block with per-port data and direction registers, strobe capture
// with interrupt, and an acknowledge generator for the peer handshake.
module tpi_multiport #(
  parameter int NPORTS  = 3,
  parameter int WIDTH   = 8,
  parameter int ACK_LEN = 4
) (
  input  logic                    clock,
  input  logic                    _reset,
  input  logic                    _cs,
  input  logic                    _write,
  input  logic [3:0]              rs,
  input  logic [WIDTH-1:0]        data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    data_oe,
  input  logic [NPORTS*WIDTH-1:0] port_in,
  output logic [NPORTS*WIDTH-1:0] port_out,
  output logic [NPORTS*WIDTH-1:0] port_dir,
  input  logic                    strobe_in,
  output logic                    ack_out,
  output logic                    irq_n,
  output logic [1:0]              dbg_ack_state
);

  // CTRL is held at least 8 bits wide so the fixed field positions always exist.
  localparam int CW      = (WIDTH >= 8) ? WIDTH : 8;
  localparam int IRQ_BIT = (WIDTH >= 8) ? 7 : WIDTH - 1;
  localparam int CTRL_RS = 2 * NPORTS;
  localparam int STAT_RS = 2 * NPORTS + 1;
  localparam logic [CW-1:0] CTRL_MASK = CW'(8'h0F) | (CW'(1) << IRQ_BIT);
  localparam logic [7:0]    CNT_LOAD  = 8'(ACK_LEN - 1);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_HSHAKE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } ack_state_t;

  logic [WIDTH-1:0]        pr_q  [NPORTS];
  logic [WIDTH-1:0]        ddr_q [NPORTS];
  logic [CW-1:0]           ctrl_q, ctrl_d;
  logic [CW-1:0]           data_cw;
  logic                    stb_q, ovr_q;
  logic [NPORTS*WIDTH-1:0] pin_s1, pin_s2;
  logic                    strb_s1, strb_s2, strb_s3;
  ack_state_t              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    ack_d;

  int                      rs_n;
  logic                    acc, wr, rd, pr0_acc;
  logic                    ctrl_sel, stat_sel;
  logic                    strb_rise, strb_fall, edge_hit;
  logic                    stb_clr, ovr_clr;
  logic [1:0]              mode_q, mode_d;
  logic                    mode_chg;
  logic [WIDTH-1:0]        rd_val;

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_MANUAL : m;
  endfunction

  // Host bus: every clock with _cs low is exactly one access (no stall). A read returns
  // its data on the following cycle, and data_oe qualifies that cycle alone.
  assign acc      = ~_cs;
  assign wr       = acc & ~_write;
  assign rd       = acc & _write;
  assign rs_n     = int'(rs);
  assign pr0_acc  = acc && (rs_n == 0);
  assign ctrl_sel = (rs_n == CTRL_RS);
  assign stat_sel = (rs_n == STAT_RS);
  assign data_cw  = CW'(data_in);

  assign strb_rise = strb_s2 & ~strb_s3;
  assign strb_fall = ~strb_s2 & strb_s3;
  assign edge_hit  = ctrl_q[3] ? strb_rise : strb_fall;
  assign stb_clr   = (wr && stat_sel && data_cw[0]) || (rd && (rs_n == 0));
  assign ovr_clr   = wr && stat_sel && data_cw[1];

  assign ctrl_d   = (wr && ctrl_sel) ? (data_cw & CTRL_MASK) : ctrl_q;
  assign mode_q   = eff_mode(ctrl_q[1:0]);
  assign mode_d   = eff_mode(ctrl_d[1:0]);
  assign mode_chg = wr && ctrl_sel && (mode_d != mode_q);

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign port_out[g*WIDTH +: WIDTH] = pr_q[g];
    assign port_dir[g*WIDTH +: WIDTH] = ddr_q[g];
  end

  assign dbg_ack_state = state_q;

  // PR reads merge driven bits with synchronised pin levels on the input bits.
  always_comb begin
    rd_val = '0;
    for (int n = 0; n < NPORTS; n++) begin
      if (rs_n == n)
        rd_val = (pr_q[n] & ddr_q[n]) | (pin_s2[n*WIDTH +: WIDTH] & ~ddr_q[n]);
      if (rs_n == NPORTS + n)
        rd_val = ddr_q[n];
    end
    if (ctrl_sel) rd_val = WIDTH'(ctrl_q);
    if (stat_sel) rd_val = WIDTH'({ovr_q, stb_q});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mode_chg) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pr0_acc && mode_q == MODE_PULSE) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_LOAD;
          end else if (pr0_acc && mode_q == MODE_HSHAKE) begin
            state_d = ST_WAIT;
          end
        end
        ST_PULSE: begin
          if (pr0_acc)          cnt_d   = CNT_LOAD;
          else if (cnt_q == '0) state_d = ST_IDLE;
          else                  cnt_d   = cnt_q - 8'd1;
        end
        ST_WAIT: begin
          if (strb_rise) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // ack is registered from the next state so it changes together with the state.
    ack_d = 1'b1;
    if (state_d != ST_IDLE)          ack_d = 1'b0;
    else if (mode_d == MODE_MANUAL)  ack_d = ctrl_d[2];
  end

  always_ff @(posedge clock) begin
    if (!_reset) begin
      for (int n = 0; n < NPORTS; n++) begin
        pr_q[n]  <= '0;
        ddr_q[n] <= '0;
      end
      ctrl_q   <= '0;
      stb_q    <= 1'b0;
      ovr_q    <= 1'b0;
      pin_s1   <= '0;
      pin_s2   <= '0;
      strb_s1  <= 1'b0;
      strb_s2  <= 1'b0;
      strb_s3  <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      ack_out  <= 1'b1;
      irq_n    <= 1'b1;
    end else begin
      for (int n = 0; n < NPORTS; n++) begin
        if (wr && rs_n == n)          pr_q[n]  <= data_in;
        if (wr && rs_n == NPORTS + n) ddr_q[n] <= data_in;
      end
      ctrl_q   <= ctrl_d;
      stb_q    <= edge_hit | (stb_q & ~stb_clr);
      ovr_q    <= (edge_hit & stb_q) | (ovr_q & ~ovr_clr);
      pin_s1   <= port_in;
      pin_s2   <= pin_s1;
      strb_s1  <= strobe_in;
      strb_s2  <= strb_s1;
      strb_s3  <= strb_s2;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_out <= rd ? rd_val : '0;
      data_oe  <= rd;
      ack_out  <= ack_d;
      irq_n    <= ~(stb_q & ctrl_q[IRQ_BIT]);
    end
  end

endmodule

// File: tb/tb_tpi_multiport.sv
// Bench for tpi_multiport: a register-access vector table, hand-written strobe/ack
// sequences, and randomized traffic checked against a cycle-level reference model.
module tb_tpi_multiport;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int AL = 4;

  logic            clock = 1'b0;
  logic            _reset;
  logic            _cs;
  logic            _write;
  logic [3:0]      rs;
  logic [W-1:0]    data_in;
  logic [W-1:0]    data_out;
  logic            data_oe;
  logic [NP*W-1:0] port_in;
  logic [NP*W-1:0] port_out;
  logic [NP*W-1:0] port_dir;
  logic            strobe_in;
  logic            ack_out;
  logic            irq_n;
  logic [1:0]      dbg_ack_state;

  int errors = 0;
  int checks = 0;

  tpi_multiport #(.NPORTS(NP), .WIDTH(W), .ACK_LEN(AL)) dut (
    .clock(clock), ._reset(_reset), ._cs(_cs), ._write(_write), .rs(rs),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .port_in(port_in), .port_out(port_out), .port_dir(port_dir),
    .strobe_in(strobe_in), .ack_out(ack_out), .irq_n(irq_n),
    .dbg_ack_state(dbg_ack_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    m_pr  [NP];
  logic [W-1:0]    m_ddr [NP];
  logic [7:0]      m_ctrl;
  bit              m_stb, m_ovr;
  logic [NP*W-1:0] m_pin[$];   // pins sampled at the last two edges
  bit              m_strb[$];  // strobe sampled at the last three edges
  int              m_pulse_left;
  bit              m_waiting;
  bit              m_ack, m_irq_n, m_oe;

  function automatic logic [1:0] eff(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NP; n++) begin
      m_pr[n]  = '0;
      m_ddr[n] = '0;
    end
    m_ctrl = '0; m_stb = 0; m_ovr = 0;
    m_pin.delete();  m_pin.push_back('0);  m_pin.push_back('0);
    m_strb.delete(); m_strb.push_back(0); m_strb.push_back(0); m_strb.push_back(0);
    m_pulse_left = 0; m_waiting = 0;
    m_ack = 1; m_irq_n = 1; m_oe = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [NP*W-1:0] sync;
    logic [W-1:0]    v;
    logic [1:0]      old_mode;
    bit              fell, rose, hit, acc, wr, rd, clr;
    int              r;
    if (!_reset) begin
      model_reset();
      return;
    end
    sync = m_pin[0];
    fell = m_strb[0] && !m_strb[1];
    rose = !m_strb[0] && m_strb[1];
    hit  = m_ctrl[3] ? rose : fell;
    acc  = !_cs; wr = acc && !_write; rd = acc && _write;
    r    = int'(rs);
    old_mode = eff(m_ctrl[1:0]);
    m_irq_n  = !(m_stb && m_ctrl[7]);
    m_oe     = rd;
    if (rd) begin
      v = '0;
      if (r < NP)            v = (m_pr[r] & m_ddr[r]) | (sync[r*W +: W] & ~m_ddr[r]);
      else if (r < 2*NP)     v = m_ddr[r-NP];
      else if (r == 2*NP)    v = m_ctrl;
      else if (r == 2*NP+1)  v = {6'b0, m_ovr, m_stb};
      exp_q.push_back(v);
    end
    clr   = (wr && r == 2*NP+1 && data_in[0]) || (rd && r == 0);
    m_ovr = (hit && m_stb) || (m_ovr && !(wr && r == 2*NP+1 && data_in[1]));
    m_stb = hit || (m_stb && !clr);
    if (wr && r < NP)            m_pr[r]      = data_in;
    else if (wr && r < 2*NP)     m_ddr[r-NP]  = data_in;
    else if (wr && r == 2*NP)    m_ctrl       = data_in & 8'h8F;
    if (wr && r == 2*NP && eff(m_ctrl[1:0]) != old_mode) begin
      m_pulse_left = 0; m_waiting = 0;
    end else if (old_mode == 2'b01) begin
      if (acc && r == 0)         m_pulse_left = AL;
      else if (m_pulse_left > 0) m_pulse_left--;
    end else if (old_mode == 2'b10) begin
      if (m_waiting && rose)              m_waiting = 0;
      else if (!m_waiting && acc && r == 0) m_waiting = 1;
    end
    if (m_pulse_left > 0 || m_waiting) m_ack = 0;
    else if (eff(m_ctrl[1:0]) == 2'b00) m_ack = m_ctrl[2];
    else m_ack = 1;
    m_pin.push_back(port_in);    void'(m_pin.pop_front());
    m_strb.push_back(strobe_in); void'(m_strb.pop_front());
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NP*W-1:0] eo, ed;
    for (int n = 0; n < NP; n++) begin
      eo[n*W +: W] = m_pr[n];
      ed[n*W +: W] = m_ddr[n];
    end
    chk("port_out", port_out, eo);
    chk("port_dir", port_dir, ed);
    chk("irq_n", irq_n, m_irq_n);
    chk("ack_out", ack_out, m_ack);
    chk("data_oe", data_oe, m_oe);
    if (m_oe) begin
      if (exp_q.size() == 0) chk("rd_queue", 32'd0, 32'd1);
      else                   chk("rd_data", data_out, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic bus_idle();
    _cs = 1; _write = 1; rs = '0; data_in = '0;
    step();
  endtask

  task automatic bus_wr(input logic [3:0] r, input logic [W-1:0] d);
    _cs = 0; _write = 0; rs = r; data_in = d;
    step();
    _cs = 1; _write = 1;
  endtask

  task automatic bus_rd(input logic [3:0] r);
    _cs = 0; _write = 1; rs = r; data_in = '0;
    step();
    _cs = 1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) bus_idle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         cs_n;
    logic         wr_n;
    logic [3:0]   rs;
    logic [W-1:0] din;
    logic         exp_oe;
    logic [W-1:0] exp_dout;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int k;
    int low;

    vecs[0]  = '{1'b0, 1'b0, 4'd3,  8'hF0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  8'hA5, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 4'd0,  8'h00, 1'b1, 8'hAC};
    vecs[3]  = '{1'b0, 1'b1, 4'd3,  8'h00, 1'b1, 8'hF0};
    vecs[4]  = '{1'b0, 1'b1, 4'd1,  8'h00, 1'b1, 8'hC3};
    vecs[5]  = '{1'b0, 1'b1, 4'd2,  8'h00, 1'b1, 8'h5A};
    vecs[6]  = '{1'b0, 1'b0, 4'd6,  8'hFF, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 4'd6,  8'h00, 1'b1, 8'h8F};
    vecs[8]  = '{1'b0, 1'b0, 4'd6,  8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 4'd7,  8'h00, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 4'd9,  8'h00, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 4'd12, 8'h00, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 4'd15, 8'h00, 1'b1, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 4'd15, 8'hFF, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 4'd0,  8'h00, 1'b1, 8'hAC};
    vecs[15] = '{1'b0, 1'b1, 4'd3,  8'h00, 1'b1, 8'hF0};
    vecs[16] = '{1'b0, 1'b1, 4'd6,  8'h00, 1'b1, 8'h00};
    vecs[17] = '{1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 8'h00};

    // Reset state
    _reset = 0; _cs = 1; _write = 1; rs = '0; data_in = '0;
    port_in = 24'h5AC33C; strobe_in = 1;
    model_reset();
    idle_n(3);
    chk("rst_port_out", port_out, 24'h0);
    chk("rst_port_dir", port_dir, 24'h0);
    chk("rst_ack", ack_out, 1'b1);
    chk("rst_irq", irq_n, 1'b1);
    chk("rst_oe", data_oe, 1'b0);
    _reset = 1;
    idle_n(3);

    // Register map vectors
    for (int i = 0; i < 18; i++) begin
      _cs = vecs[i].cs_n; _write = vecs[i].wr_n; rs = vecs[i].rs; data_in = vecs[i].din;
      step();
      chk($sformatf("vec%0d_oe", i), data_oe, vecs[i].exp_oe);
      if (vecs[i].exp_oe) chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_dout);
    end
    _cs = 1; _write = 1;
    chk("ddr0_pins", port_dir[7:0], 8'hF0);

    // Strobe falling edge -> interrupt latency, cleared by PR0 read
    bus_wr(4'd6, 8'h80);
    idle_n(3);
    strobe_in = 0;
    for (k = 1; k <= 12; k++) begin
      bus_idle();
      if (irq_n == 1'b0) break;
    end
    chk("irq_latency", k, 4);
    bus_rd(4'd0);
    bus_idle();
    chk("irq_cleared", irq_n, 1'b1);
    bus_rd(4'd7);
    chk("stat_after_clr", data_out, 8'h00);

    // Two strobes without clear -> overrun, then selective clear
    strobe_in = 1; idle_n(4);
    strobe_in = 0; idle_n(4);
    strobe_in = 1; idle_n(4);
    strobe_in = 0; idle_n(4);
    bus_rd(4'd7);
    chk("stat_ovr", data_out, 8'h03);
    bus_wr(4'd7, 8'h02);
    bus_rd(4'd7);
    chk("stat_ovr_clr", data_out, 8'h01);
    bus_wr(4'd7, 8'h01);

    // Pulse mode: ack low for exactly ACK_LEN clocks after the PR0 access
    bus_wr(4'd6, 8'h01);
    bus_idle();
    chk("pulse_idle_ack", ack_out, 1'b1);
    bus_rd(4'd0);
    chk("pulse_start", ack_out, 1'b0);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      bus_idle();
      if (ack_out == 1'b0) low++;
      else break;
    end
    chk("pulse_len", low, AL);

    // Handshake mode: ack low until synchronised strobe rise, then reset during WAIT
    bus_wr(4'd6, 8'h02);
    bus_idle();
    chk("hs_idle_ack", ack_out, 1'b1);
    bus_wr(4'd0, 8'h11);
    chk("hs_wait_ack", ack_out, 1'b0);
    idle_n(3);
    strobe_in = 1;
    for (k = 1; k <= 12; k++) begin
      bus_idle();
      if (ack_out == 1'b1) break;
    end
    chk("hs_release", k, 3);
    strobe_in = 0; idle_n(4);
    bus_wr(4'd0, 8'h22);
    chk("hs_wait2_ack", ack_out, 1'b0);
    _reset = 0;
    bus_idle();
    chk("rst_wait_ack", ack_out, 1'b1);
    chk("rst_wait_out", port_out, 24'h0);
    chk("rst_wait_dir", port_dir, 24'h0);
    _reset = 1;
    for (int r = NP; r <= 2*NP+1; r++) begin
      bus_rd(4'(r));
      chk($sformatf("rst_reg%0d", r), data_out, 8'h00);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      _reset  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      _cs     = ($urandom_range(0, 1) == 0);
      _write  = ($urandom_range(0, 1) == 0);
      rs      = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(0, 15));
      data_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0)  port_in = 24'($urandom);
      if ($urandom_range(0, 9) < 2)   strobe_in = ~strobe_in;
      step();
    end
    _reset = 1; _cs = 1; _write = 1;
    idle_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
